// File: rtl/sha256_block_ctrl_pkg.sv
// sha256_pkg: shared SHA-256 constants, controller state enum and
// round helper functions for the iterative block controller.
package sha256_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        ACCUM,
        DONE
    } state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] RightRot(input logic [31:0] x,
                                             input logic [4:0]  n);
        return (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [31:0] CH(input logic [31:0] x,
                                       input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] MAJ(input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] EP0(input logic [31:0] x);
        return RightRot(x, 5'd2) ^ RightRot(x, 5'd13) ^ RightRot(x, 5'd22);
    endfunction

    function automatic logic [31:0] EP1(input logic [31:0] x);
        return RightRot(x, 5'd6) ^ RightRot(x, 5'd11) ^ RightRot(x, 5'd25);
    endfunction

    function automatic logic [31:0] SSIG0(input logic [31:0] x);
        return RightRot(x, 5'd7) ^ RightRot(x, 5'd18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] SSIG1(input logic [31:0] x);
        return RightRot(x, 5'd17) ^ RightRot(x, 5'd19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_block_ctrl_round.sv
// sha256_round: one combinational SHA-256 round plus schedule word.
// Ports: work_in {a..h}, k, w_win {W0..W15} (W0 in MSBs) -> work_out, w_next.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] work_in,
    input  logic [31:0]  k,
    input  logic [511:0] w_win,
    output logic [255:0] work_out,
    output logic [31:0]  w_next
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] w0, w1, w9, w14;
    logic [31:0] temp1, temp2;

    assign {a, b, c, d, e, f, g, h} = work_in;

    assign w0  = w_win[511:480];
    assign w1  = w_win[479:448];
    assign w9  = w_win[223:192];
    assign w14 = w_win[63:32];

    assign temp1 = h + EP1(e) + CH(e, f, g) + k + w0;
    assign temp2 = EP0(a) + MAJ(a, b, c);

    assign work_out = {temp1 + temp2, a, b, c, d + temp1, e, f, g};
    assign w_next   = SSIG1(w14) + w9 + SSIG0(w1) + w0;

endmodule

// File: rtl/sha256_block_ctrl.sv
// sha256_block_ctrl: iterative SHA-256 over up to MAX_BLOCKS padded blocks.
// Ports: in_valid/in_ready/msg/num_blocks in, out_valid/out_ready/digest out, busy.
module sha256_block_ctrl
    import sha256_pkg::*;
#(
    parameter int MAX_BLOCKS = 20,
    parameter int CNT_W      = $clog2(MAX_BLOCKS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [MAX_BLOCKS*512-1:0] msg,
    input  logic [CNT_W-1:0]        num_blocks,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [255:0]            digest,
    output logic                    busy
);

    localparam logic [CNT_W-1:0] MAXB = CNT_W'(MAX_BLOCKS);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t state, state_nx;

    logic [511:0]     blk_mem [MAX_BLOCKS];
    logic [511:0]     msg_blk [MAX_BLOCKS];
    logic [CNT_W-1:0] nblk, blk_idx, nblk_in;
    logic [31:0]      hv [8];
    logic [31:0]      wk [8];
    logic [31:0]      w  [16];
    logic [5:0]       rnd;

    logic [511:0] blk_cur;
    logic [31:0]  blk_w [16];
    logic [255:0] wk_nx;
    logic [31:0]  wk_nx_w [8];
    logic [31:0]  w_new;
    logic         accept, last_blk;

    for (genvar g = 0; g < MAX_BLOCKS; g++) begin : g_blk
        assign msg_blk[g] = msg[MAX_BLOCKS*512-1-g*512 -: 512];
    end

    assign blk_cur = blk_mem[blk_idx];

    for (genvar g = 0; g < 16; g++) begin : g_word
        assign blk_w[g] = blk_cur[511-32*g -: 32];
    end

    for (genvar g = 0; g < 8; g++) begin : g_work
        assign wk_nx_w[g] = wk_nx[255-32*g -: 32];
    end

    sha256_round u_round (
        .work_in  ({wk[0], wk[1], wk[2], wk[3],
                    wk[4], wk[5], wk[6], wk[7]}),
        .k        (K[rnd]),
        .w_win    ({w[0],  w[1],  w[2],  w[3],
                    w[4],  w[5],  w[6],  w[7],
                    w[8],  w[9],  w[10], w[11],
                    w[12], w[13], w[14], w[15]}),
        .work_out (wk_nx),
        .w_next   (w_new)
    );

    assign nblk_in  = (num_blocks > MAXB) ? MAXB : num_blocks;
    assign accept   = in_valid && in_ready;
    assign last_blk = (blk_idx == nblk - ONE);
    assign digest   = {hv[0], hv[1], hv[2], hv[3],
                       hv[4], hv[5], hv[6], hv[7]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nx = (nblk_in == '0) ? DONE : LOAD;
                end
            end
            LOAD: state_nx = ROUND;
            ROUND: begin
                if (rnd == 6'd63) begin
                    state_nx = ACCUM;
                end
            end
            ACCUM: state_nx = last_blk ? DONE : LOAD;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_BLOCKS; i++) blk_mem[i] <= '0;
            for (int i = 0; i < 8; i++) hv[i] <= '0;
            for (int i = 0; i < 8; i++) wk[i] <= '0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
            nblk    <= '0;
            blk_idx <= '0;
            rnd     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int i = 0; i < MAX_BLOCKS; i++) blk_mem[i] <= msg_blk[i];
                        for (int i = 0; i < 8; i++) hv[i] <= IV[i];
                        nblk    <= nblk_in;
                        blk_idx <= '0;
                    end
                end
                LOAD: begin
                    for (int i = 0; i < 16; i++) w[i] <= blk_w[i];
                    for (int i = 0; i < 8; i++) wk[i] <= hv[i];
                    rnd <= '0;
                end
                ROUND: begin
                    for (int i = 0; i < 8; i++) wk[i] <= wk_nx_w[i];
                    for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                    w[15] <= w_new;
                    rnd   <= rnd + 6'd1;
                end
                ACCUM: begin
                    for (int i = 0; i < 8; i++) hv[i] <= hv[i] + wk[i];
                    if (!last_blk) begin
                        blk_idx <= blk_idx + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// tb_sha256_block_ctrl: directed and random checks of sha256_block_ctrl
// against known digests and a full-schedule SHA-256 model.
module tb_sha256_block_ctrl;

    localparam int MAXB = 20;
    localparam int MSGW = MAXB * 512;
    localparam int NW   = MAXB * 16;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] D_IV  =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] D_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMP =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_TWO =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [MSGW-1:0] msg = '0;
    logic [4:0]      num_blocks = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [255:0]    digest;
    logic            busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] mw [NW];

    always #5 clk = ~clk;

    sha256_block_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .msg        (msg),
        .num_blocks (num_blocks),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .digest     (digest),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rot(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic void clear_mw();
        for (int i = 0; i < NW; i++) mw[i] = '0;
    endfunction

    function automatic void rand_mw(input int n);
        for (int i = 0; i < n * 16; i++) mw[i] = $urandom;
    endfunction

    function automatic logic [MSGW-1:0] pack();
        logic [MSGW-1:0] m;
        m = '0;
        for (int i = 0; i < NW; i++) m = {m[MSGW-33:0], mw[i]};
        return m;
    endfunction

    // Textbook SHA-256 with the whole 64-word schedule expanded up front.
    function automatic logic [255:0] ref_hash(input int n);
        logic [31:0] hh [8];
        logic [31:0] v  [8];
        logic [31:0] ws [64];
        logic [31:0] t1, t2, s0, s1;
        hh = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        for (int b = 0; b < n; b++) begin
            for (int t = 0; t < 16; t++) ws[t] = mw[b*16+t];
            for (int t = 16; t < 64; t++) begin
                s0 = rot(ws[t-15], 7) ^ rot(ws[t-15], 18) ^ (ws[t-15] >> 3);
                s1 = rot(ws[t-2], 17) ^ rot(ws[t-2], 19) ^ (ws[t-2] >> 10);
                ws[t] = s1 + ws[t-7] + s0 + ws[t-16];
            end
            for (int i = 0; i < 8; i++) v[i] = hh[i];
            for (int t = 0; t < 64; t++) begin
                t1 = v[7] + (rot(v[4], 6) ^ rot(v[4], 11) ^ rot(v[4], 25))
                   + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + ws[t];
                t2 = (rot(v[0], 2) ^ rot(v[0], 13) ^ rot(v[0], 22))
                   + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
                for (int i = 7; i > 0; i--) v[i] = v[i-1];
                v[4] = v[4] + t1;
                v[0] = t1 + t2;
            end
            for (int i = 0; i < 8; i++) hh[i] = hh[i] + v[i];
        end
        return {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};
    endfunction

    // lat counts rising edges after the accepting edge until out_valid
    // is seen; for N=0 it is already up in the very next cycle.
    task automatic run(input logic [4:0] n, input logic [255:0] exp,
                       input string tag, input int hold);
        int nc, lat, stable;
        logic [255:0] d0;
        nc  = (int'(n) > MAXB) ? MAXB : int'(n);
        lat = 0;
        @(negedge clk);
        msg        = pack();
        num_blocks = n;
        in_valid   = 1'b1;
        chk({tag, "_in_ready"}, 256'(in_ready), 256'(1));
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        msg        = {MSGW/32{$urandom}};
        num_blocks = 5'($urandom);
        while (out_valid !== 1'b1 && lat < 2000) begin
            if (lat == 5) begin
                in_valid = 1'b1;
                chk({tag, "_busy_rdy"}, 256'(in_ready), 256'(0));
                chk({tag, "_busy"}, 256'(busy), 256'(1));
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat++;
        end
        chk({tag, "_latency"}, 256'(lat), 256'(nc == 0 ? 0 : 66 * nc));
        chk({tag, "_digest"}, digest, exp);
        if (hold > 0) begin
            d0     = digest;
            stable = 1;
            repeat (hold) begin
                @(posedge clk);
                #1;
                if (out_valid !== 1'b1 || digest !== d0) stable = 0;
            end
            chk({tag, "_hold_stable"}, 256'(stable), 256'(1));
            chk({tag, "_hold_digest"}, digest, exp);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_drain_ov"}, 256'(out_valid), 256'(0));
        chk({tag, "_drain_rdy"}, 256'(in_ready), 256'(1));
    endtask

    task automatic load_abc();
        clear_mw();
        mw[0]  = 32'h61626380;
        mw[15] = 32'h00000018;
    endtask

    initial begin
        logic [4:0] n;
        #2;
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_digest", digest, 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        @(negedge clk);
        rst_n = 1'b1;

        load_abc();
        run(5'd1, D_ABC, "abc", 0);

        clear_mw();
        mw[0] = 32'h80000000;
        run(5'd1, D_EMP, "empty", 0);

        clear_mw();
        mw[0]  = 32'h61626364; mw[1]  = 32'h62636465;
        mw[2]  = 32'h63646566; mw[3]  = 32'h64656667;
        mw[4]  = 32'h65666768; mw[5]  = 32'h66676869;
        mw[6]  = 32'h6768696a; mw[7]  = 32'h68696a6b;
        mw[8]  = 32'h696a6b6c; mw[9]  = 32'h6a6b6c6d;
        mw[10] = 32'h6b6c6d6e; mw[11] = 32'h6c6d6e6f;
        mw[12] = 32'h6d6e6f70; mw[13] = 32'h6e6f7071;
        mw[14] = 32'h80000000;
        mw[31] = 32'h000001c0;
        run(5'd2, D_TWO, "two_blk", 50);

        rand_mw(MAXB);
        run(5'd0, D_IV, "zero_blk", 3);

        load_abc();
        @(negedge clk);
        msg        = pack();
        num_blocks = 5'd1;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (31) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 256'(out_valid), 256'(0));
        chk("abort_digest", digest, 256'(0));
        chk("abort_busy", 256'(busy), 256'(0));
        chk("abort_in_ready", 256'(in_ready), 256'(1));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", 256'(in_ready), 256'(1));
        run(5'd1, D_ABC, "abc_rerun", 0);

        for (int it = 0; it < 3; it++) begin
            n = 5'($urandom_range(1, 3));
            clear_mw();
            rand_mw(int'(n));
            run(n, ref_hash(int'(n)), "rand", 0);
        end

        rand_mw(MAXB);
        run(5'd25, ref_hash(MAXB), "clamp", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
